// File: rtl/dmem_responder.sv
// Single-cycle data-memory responder: word-addressed RAM with a sticky access-fault tracker.
// Optional MMIO block (CYCLE / IO_OUT / STATUS at 0xFFFF0000) enabled by macro DMEM_RESPONDER_MMIO_EN.
module dmem_responder #(
    parameter int DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_write_data,
    output logic [31:0] dmem_read_data,
    output logic [31:0] io_out,
    output logic        fault,
    output logic [31:0] fault_addr
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   ram_r [DEPTH];
    logic [AW-1:0] idx_s;
    logic          misaligned_s;
    logic          ram_hit_s;
    logic          mmio_hit_s;
    logic          fault_ev_s;
    logic          rd_ok_s;
    logic          wr_ok_s;
    logic          clr_s;
    logic          fault_r;
    logic [31:0]   fault_addr_r;
    logic [7:0]    fault_count_r;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'h01;
    endfunction

    assign idx_s = dmem_addr[AW+1:2];

    // Address decode and access qualification.
    always_comb begin
        misaligned_s = (dmem_addr[1:0] != 2'b00);
        ram_hit_s    = (dmem_addr[31:AW+2] == {(30-AW){1'b0}});
`ifdef DMEM_RESPONDER_MMIO_EN
        mmio_hit_s   = (dmem_addr[31:4] == 28'hFFFF000) && (dmem_addr[3:2] != 2'b11);
`else
        mmio_hit_s   = 1'b0;
`endif
        fault_ev_s   = (dmem_read | dmem_write) &
                       (misaligned_s | ~(ram_hit_s | mmio_hit_s) | (dmem_read & dmem_write));
        rd_ok_s      = dmem_read & ~dmem_write & ~fault_ev_s;
        wr_ok_s      = dmem_write & ~dmem_read & ~fault_ev_s;
    end

`ifdef DMEM_RESPONDER_MMIO_EN
    logic [31:0] cycle_r;
    logic [31:0] io_out_r;
    logic [31:0] status_s;

    assign status_s = {16'h0000, fault_count_r, 7'h00, fault_r};
    assign clr_s    = wr_ok_s & mmio_hit_s & (dmem_addr[3:2] == 2'b10) & dmem_write_data[0];
    assign io_out   = io_out_r;

    // Free-running cycle counter and the IO_OUT register; CYCLE writes are silently dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_r  <= 32'h0000_0000;
            io_out_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_r + 32'h0000_0001;
            if (wr_ok_s && mmio_hit_s && (dmem_addr[3:2] == 2'b01)) begin
                io_out_r <= dmem_write_data;
            end
        end
    end
`else
    assign clr_s  = 1'b0;
    assign io_out = 32'h0000_0000;
`endif

    // Zero-latency load path; anything not a clean read returns zero.
    always_comb begin
        dmem_read_data = 32'h0000_0000;
        if (rd_ok_s && ram_hit_s) begin
            dmem_read_data = ram_r[idx_s];
`ifdef DMEM_RESPONDER_MMIO_EN
        end else if (rd_ok_s && mmio_hit_s) begin
            case (dmem_addr[3:2])
                2'b00:   dmem_read_data = cycle_r;
                2'b01:   dmem_read_data = io_out_r;
                2'b10:   dmem_read_data = status_s;
                default: dmem_read_data = 32'h0000_0000;
            endcase
`endif
        end else begin
            dmem_read_data = 32'h0000_0000;
        end
    end

    // RAM store port; a write still pending when reset rises is dropped.
    always_ff @(posedge clock) begin
        if (!reset && wr_ok_s && ram_hit_s) begin
            ram_r[idx_s] <= dmem_write_data;
        end
    end

    // Sticky fault tracker; a new fault outranks a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_r       <= 1'b0;
            fault_addr_r  <= 32'h0000_0000;
            fault_count_r <= 8'h00;
        end else if (fault_ev_s) begin
            fault_r <= 1'b1;
            if (!fault_r || clr_s) begin
                fault_addr_r <= dmem_addr;
            end
            fault_count_r <= clr_s ? 8'h01 : sat_inc8(fault_count_r);
        end else if (clr_s) begin
            fault_r       <= 1'b0;
            fault_addr_r  <= 32'h0000_0000;
            fault_count_r <= 8'h00;
        end
    end

    assign fault      = fault_r;
    assign fault_addr = fault_addr_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=256).
// MMIO checks are built only when DMEM_RESPONDER_MMIO_EN is defined.
module tb_dmem_responder;
    logic        clock;
    logic        reset;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_write_data;
    logic [31:0] dmem_read_data;
    logic [31:0] io_out;
    logic        fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH(256)) dut (
        .clock          (clock),
        .reset          (reset),
        .dmem_read      (dmem_read),
        .dmem_write     (dmem_write),
        .dmem_addr      (dmem_addr),
        .dmem_write_data(dmem_write_data),
        .dmem_read_data (dmem_read_data),
        .io_out         (io_out),
        .fault          (fault),
        .fault_addr     (fault_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one bus request just after the falling edge.
    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        dmem_read       = r;
        dmem_write      = w;
        dmem_addr       = a;
        dmem_write_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] fcount();
        return {24'h000000, dut.fault_count_r};
    endfunction

    logic [31:0] c1;
    logic [31:0] c2;

    initial begin
        reset = 1'b1;
        dmem_read = 1'b0;
        dmem_write = 1'b0;
        dmem_addr = 32'h0;
        dmem_write_data = 32'h0;
        #2;
        check_eq("rst_fault", {31'h0, fault}, 32'h0);
        check_eq("rst_fault_addr", fault_addr, 32'h0);
        check_eq("rst_io_out", io_out, 32'h0);
        check_eq("rst_count", fcount(), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        drive(1'b0, 1'b1, 32'h0000_0008, 32'h0BAD_F00D); tick();
        drive(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678); tick();
        drive(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D); tick();
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_eq("rd_0x10", dmem_read_data, 32'h1234_5678);
        check_eq("no_fault", {31'h0, fault}, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
        check_eq("rd_0x8", dmem_read_data, 32'h0BAD_F00D);
        tick();

        // Misaligned store, then unmapped load.
        drive(1'b0, 1'b1, 32'h0000_0012, 32'hDEAD_BEEF);
        check_eq("mis_rdata", dmem_read_data, 32'h0);
        tick();
        check_eq("mis_fault", {31'h0, fault}, 32'h1);
        check_eq("mis_faddr", fault_addr, 32'h0000_0012);
        check_eq("mis_count", fcount(), 32'h1);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_eq("mis_no_write", dmem_read_data, 32'h1234_5678);
        tick();
        drive(1'b1, 1'b0, 32'h0000_4000, 32'h0);
        check_eq("unmap_rdata", dmem_read_data, 32'h0);
        tick();
        check_eq("unmap_faddr", fault_addr, 32'h0000_0012);
        check_eq("unmap_count", fcount(), 32'h2);

        // Simultaneous read and write.
        drive(1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF);
        check_eq("both_rdata", dmem_read_data, 32'h0);
        tick();
        check_eq("both_fault", {31'h0, fault}, 32'h1);
        check_eq("both_count", fcount(), 32'h3);
        drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
        check_eq("both_no_write", dmem_read_data, 32'h0BAD_F00D);
        tick();

        drive(1'b0, 1'b0, 32'h0000_0003, 32'h0); tick(); tick();
        check_eq("idle_count", fcount(), 32'h3);

`ifdef DMEM_RESPONDER_MMIO_EN
        drive(1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_00A5); tick();
        check_eq("io_out", io_out, 32'h0000_00A5);
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
        check_eq("io_rd", dmem_read_data, 32'h0000_00A5);
        drive(1'b1, 1'b0, 32'hFFFF_0000, 32'h0);
        c1 = dmem_read_data;
        repeat (5) @(negedge clock);
        #1;
        c2 = dmem_read_data;
        check_eq("cycle_delta", c2 - c1, 32'h5);
        drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h0); tick();
        check_eq("cycle_wr_count", fcount(), 32'h3);
        drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        check_eq("status_rd", dmem_read_data, 32'h0000_0301);
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0000); tick();
        check_eq("clr0_fault", {31'h0, fault}, 32'h1);
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0001); tick();
        check_eq("clr_fault", {31'h0, fault}, 32'h0);
        check_eq("clr_count", fcount(), 32'h0);
        check_eq("clr_faddr", fault_addr, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0006, 32'h0); tick();
        check_eq("refault_faddr", fault_addr, 32'h0000_0006);
`else
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
        check_eq("mmio_off_rdata", dmem_read_data, 32'h0);
        tick();
        check_eq("mmio_off_count", fcount(), 32'h4);
        check_eq("mmio_off_io", io_out, 32'h0);
`endif

        // Asynchronous reset between edges with a RAM write in flight.
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h5555_5555);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_io_out", io_out, 32'h0);
        check_eq("arst_fault", {31'h0, fault}, 32'h0);
        check_eq("arst_faddr", fault_addr, 32'h0);
        check_eq("arst_count", fcount(), 32'h0);
        @(posedge clock);
        @(negedge clock);
        dmem_write = 1'b0;
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        check_eq("arst_wr_dropped", dmem_read_data, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_eq("arst_ram_kept", dmem_read_data, 32'h1234_5678);

        // Saturation of the fault counter.
        drive(1'b1, 1'b0, 32'h0000_0001, 32'h0); tick();
        for (int i = 1; i < 300; i++) begin
            drive(1'b1, 1'b0, 32'h0000_0005, 32'h0); tick();
        end
        check_eq("sat_count", fcount(), 32'h0000_00FF);
        check_eq("sat_fault", {31'h0, fault}, 32'h1);
        check_eq("sat_faddr", fault_addr, 32'h0000_0001);
`ifdef DMEM_RESPONDER_MMIO_EN
        drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        check_eq("sat_status", dmem_read_data, 32'h0000_FF01);
`endif
        drive(1'b0, 1'b0, 32'h0, 32'h0); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
